// File: rtl/gpio_pkg.sv
// gpio_pkg: register map, reserved-read value and bus helpers
// shared by the GPIO pad controller files.
package gpio_pkg;

    localparam logic [2:0] ADDR_OUT  = 3'd0;
    localparam logic [2:0] ADDR_OE   = 3'd1;
    localparam logic [2:0] ADDR_PU   = 3'd2;
    localparam logic [2:0] ADDR_PD   = 3'd3;
    localparam logic [2:0] ADDR_IN   = 3'd4;
    localparam logic [2:0] ADDR_IEN  = 3'd5;
    localparam logic [2:0] ADDR_IST  = 3'd6;
    localparam logic [2:0] ADDR_RSVD = 3'd7;

    localparam logic [31:0] RSVD_RDATA = 32'h0000_0000;

    // Expand byte strobes into a 32-bit bit mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: one pad input bit through a 2-flop synchronizer
// plus a third flop for rising-edge detection.
module gpio_sync_edge
    import gpio_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic arm,
    input  logic y,
    output logic level,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    // Sync chain; the if() form turns an unknown pad value into 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            if (y) begin
                s1 <= 1'b1;
            end else begin
                s1 <= 1'b0;
            end
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    // arm stays low until s3 holds a real post-reset sample,
    // so a pad already high at reset release is not an edge.
    assign rise  = arm & s2 & ~s3;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: memory-mapped control of WIDTH bidirectional
// pull-up/pull-down pads with rising-edge interrupts.
module gpio_pad_ctrl
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [2:0]       iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    output logic [WIDTH-1:0] pad_a,
    output logic [WIDTH-1:0] pad_en_n,
    output logic [WIDTH-1:0] pad_puen,
    output logic [WIDTH-1:0] pad_pden,
    input  logic [WIDTH-1:0] pad_y,
    output logic             irq
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] oe_q;
    logic [WIDTH-1:0] pu_q;
    logic [WIDTH-1:0] pd_q;
    logic [WIDTH-1:0] ien_q;
    logic [WIDTH-1:0] ist_q;
    logic [WIDTH-1:0] in_v;
    logic [WIDTH-1:0] rise_v;
    logic [WIDTH-1:0] wm;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] clr;
    logic [31:0]      bmask;
    logic [31:0]      rd_word;
    logic [2:0]       arm_q;
    logic             ready_q;
    logic             irq_q;
    logic             wr;
    logic             unused_ok;

    assign bmask = byte_mask(iomem_wstrb);
    assign wm    = bmask[WIDTH-1:0];
    assign wd    = iomem_wdata[WIDTH-1:0];
    assign wr    = ready_q & iomem_valid & (|iomem_wstrb);
    assign clr   = (wr && iomem_addr == ADDR_IST) ? (wd & wm) : '0;

    assign unused_ok = ^{iomem_wdata, bmask};

    // One-cycle acknowledge; never asserted two cycles in a row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= iomem_valid & ~ready_q;
        end
    end

    // Byte-lane writes to the read/write control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
            oe_q  <= '0;
            pu_q  <= '0;
            pd_q  <= '0;
            ien_q <= '0;
        end else if (wr) begin
            unique case (iomem_addr)
                ADDR_OUT: out_q <= (out_q & ~wm) | (wd & wm);
                ADDR_OE:  oe_q  <= (oe_q  & ~wm) | (wd & wm);
                ADDR_PU:  pu_q  <= (pu_q  & ~wm) | (wd & wm);
                ADDR_PD:  pd_q  <= (pd_q  & ~wm) | (wd & wm);
                ADDR_IEN: ien_q <= (ien_q & ~wm) | (wd & wm);
                default: ;
            endcase
        end
    end

    // Arm edge detection three cycles after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arm_q <= '0;
        end else begin
            arm_q <= {arm_q[1:0], 1'b1};
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_sync_edge u_se (
            .clk   (clk),
            .reset (reset),
            .arm   (arm_q[2]),
            .y     (pad_y[i]),
            .level (in_v[i]),
            .rise  (rise_v[i])
        );
    end

    // Sticky status: a new edge beats a same-cycle write-one-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ist_q <= '0;
        end else begin
            ist_q <= (ist_q & ~clr) | rise_v;
        end
    end

    // Registered level interrupt from enabled status bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(ist_q & ien_q);
        end
    end

    // Read mux; unused upper bits stay 0.
    always_comb begin
        rd_word = '0;
        unique case (iomem_addr)
            ADDR_OUT: rd_word[WIDTH-1:0] = out_q;
            ADDR_OE:  rd_word[WIDTH-1:0] = oe_q;
            ADDR_PU:  rd_word[WIDTH-1:0] = pu_q;
            ADDR_PD:  rd_word[WIDTH-1:0] = pd_q;
            ADDR_IN:  rd_word[WIDTH-1:0] = in_v;
            ADDR_IEN: rd_word[WIDTH-1:0] = ien_q;
            ADDR_IST: rd_word[WIDTH-1:0] = ist_q;
            default:  rd_word = RSVD_RDATA;
        endcase
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = ready_q ? rd_word : '0;
    assign irq         = irq_q;

    assign pad_a    = out_q;
    assign pad_en_n = ~oe_q;
    assign pad_puen = pu_q;
    assign pad_pden = pd_q & ~pu_q;

endmodule

// File: doc/gpio_pad_ctrl.md
GPIO_PAD_CTRL -- requirements
Module: gpio_pad_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: number of io_bidirectional_pu_pd pads controlled (1..32).
REQ-002 SHALL have `clk`, input, 1 bit: single clock for all state.
REQ-003 SHALL have `reset`, input, 1 bit: asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have `iomem_valid`, input, 1 bit: bus request.
REQ-005 SHALL have `iomem_ready`, output, 1 bit: one-cycle acknowledge.
REQ-006 SHALL have `iomem_wstrb`, input, 4 bits: byte write strobes; 0 means read.
REQ-007 SHALL have `iomem_addr`, input, 3 bits: word offset.
REQ-008 SHALL have `iomem_wdata`, input, 32 bits: write data.
REQ-009 SHALL have `iomem_rdata`, output, 32 bits: read data, valid while `iomem_ready`=1.
REQ-010 SHALL have `pad_a`, output, WIDTH bits: drives pad cell A.
REQ-011 SHALL have `pad_en_n`, output, WIDTH bits: drives pad cell EN; 0 = drive.
REQ-012 SHALL have `pad_puen`, output, WIDTH bits: drives pad cell PUEN.
REQ-013 SHALL have `pad_pden`, output, WIDTH bits: drives pad cell PDEN.
REQ-014 SHALL have `pad_y`, input, WIDTH bits: from pad cell Y; asynchronous; may be X.
REQ-015 SHALL have `irq`, output, 1 bit: level interrupt.

Function
REQ-016 SHALL decode the register map: 0 OUT rw, 1 OE rw (1=drive), 2 PU rw, 3 PD rw, 4 IN ro, 5 IRQ_EN rw, 6 IRQ_STAT w1c, 7 reads 0 and ignores writes.
REQ-017 SHALL leave bits >= WIDTH unwritable and read them as 0.
REQ-018 SHALL assert `iomem_ready` for exactly one cycle, in the cycle after `iomem_valid` is first sampled high, and never in two consecutive cycles.
REQ-019 SHALL apply a write on the ready cycle, per byte lane enabled by `iomem_wstrb`.
REQ-020 SHALL drive `iomem_rdata` to 0 whenever `iomem_ready`=0.
REQ-021 SHALL drive `pad_a` = OUT and `pad_en_n` = ~OE, both combinationally from registers.
REQ-022 SHALL drive `pad_puen` = PU and `pad_pden` = PD & ~PU, so that pull-up wins and PUEN and PDEN are never both 1 on one bit.
REQ-023 SHALL pass `pad_y` through a 2-flop synchronizer; IN = second-stage value.
REQ-024 SHALL treat X on `pad_y` as 0 at the first flop, so unpowered pads cannot propagate X.
REQ-025 SHALL use a third flop for edge detect; a rising edge is IN=1 with prev=0.
REQ-026 SHALL set IRQ_STAT[i] on a rising edge of bit i, regardless of IRQ_EN.
REQ-027 SHALL clear IRQ_STAT[i] when a 1 is written to it.
REQ-028 SHALL let set win when a set and a clear of the same bit occur in the same cycle.
REQ-029 SHALL register `irq` = |(IRQ_STAT & IRQ_EN), so `irq` rises 1 cycle after STAT/EN update.
REQ-030 SHALL give a total latency of 4 clk from a `pad_y` rise to `irq` (2 sync, 1 STAT, 1 irq).

Reset
REQ-031 SHALL, on `reset`, clear all registers and sync/edge flops to 0, leaving `pad_en_n` all 1 (pads tri-stated), `pad_a`/`pad_puen`/`pad_pden`/`irq`/`iomem_ready` all 0, and `iomem_rdata` 0.
REQ-032 SHALL abort a transaction in flight when reset is asserted, with no ready after reset deasserts until a new `iomem_valid` is sampled.
REQ-033 SHALL NOT report a pad already high at reset release as an edge.

Structure
REQ-034 SHALL define register offsets and the reserved-read value in shared package `gpio_pkg`.
REQ-035 SHALL use one sub-module, `gpio_sync_edge`, per-bit synchronizer plus edge detect, instantiated WIDTH-wide.

Verification
REQ-036 SHALL cover: after reset -> `pad_en_n`=16'hFFFF, `irq`=0, read offset 4 = 0 with pads 0.
REQ-037 SHALL cover: write OE=16'h00F0, OUT=16'h0030 -> `pad_en_n`=16'hFF0F, `pad_a`=16'h0030 one cycle after ready.
REQ-038 SHALL cover: PU=16'h0001, PD=16'h0003 -> `pad_puen`=16'h0001, `pad_pden`=16'h0002.
REQ-039 SHALL cover: IRQ_EN=16'h0004; `pad_y[2]` 0->1 -> `irq`=1 exactly 4 clk later; write IRQ_STAT=16'h0004 -> `irq`=0 next cycle.
REQ-040 SHALL cover: w1c to bit 2 in the same cycle as a new edge on bit 2 -> IRQ_STAT[2] stays 1.
REQ-041 SHALL cover: `iomem_wstrb`=4'b0001 writing 32'hFFFF to OUT -> OUT=16'h00FF; `reset` pulse mid-transaction -> no stray ready.
